rr_port_arbiter: RTL and testbench
==================================

Name: rr_port_arbiter

Overview:
Round-robin arbiter that shares the single DUT output port between NUM_REQ input requesters on a packet basis. A grant is held from the first beat to the end of packet, then passes to the next requester in rotation. Sits between the per-port input queues and dut_top's output path, in the same clk domain as the testbench interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ), width of grant index
MAX_HOLD, 64, watchdog limit in cycles (used only with ARB_WATCHDOG_EN)
CNT_W, 8, width of beat counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  request per requester, level, held until granted packet ends
beat_valid  input  1  owner transferred one beat this cycle
last  input  1  qualifies beat_valid: final beat of packet
grant  output  NUM_REQ  one-hot grant, registered
grant_idx  output  IDX_W  index of current owner, valid when busy
busy  output  1  grant held
beat_cnt  output  CNT_W  beats accepted in current packet, saturating
timeout  output  1  one-cycle pulse on watchdog forced release
timeout_idx  output  IDX_W  owner at time of forced release

Behaviour:
- Reset (reset=0, async): grant=0, grant_idx=0, busy=0, beat_cnt=0, timeout=0, timeout_idx=0, ptr=0, state=IDLE. Deassertion is synchronized externally; block acts on the first rising edge after reset=1.
- States: IDLE, GRANT.
- IDLE: if req!=0, winner = first set bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ. Next edge: grant=one-hot(winner), grant_idx=winner, busy=1, beat_cnt=0, ptr=(winner+1) mod NUM_REQ, state=GRANT. If req==0: stay, outputs unchanged.
- Latency: req sampled high at edge N -> grant visible after edge N+1's update (1 cycle).
- GRANT: beat_valid without last -> beat_cnt+1, saturating at 2^CNT_W-1. beat_valid&last -> next edge: grant=0, busy=0, state=IDLE; beat_cnt holds final count (incl. last beat) until next grant.
- Owner drops req[grant_idx] while in GRANT without last: abandon; release exactly as for last, no timeout pulse.
- Release-to-next-grant: one mandatory IDLE cycle; no back-to-back grants.
- Requests from non-owners in GRANT are ignored, not latched; they win only if still asserted in IDLE.
- beat_valid/last in IDLE: ignored.
- Single requester repeatedly: regranted every packet (ptr wraps past it, search returns to it).
- Exactly one grant bit set whenever busy=1; grant=0 whenever busy=0.

Optional Feature:
ARB_WATCHDOG_EN: when defined, hold counter clears on entering GRANT, increments each GRANT cycle; on the cycle it equals MAX_HOLD-1 without a release, next edge forces release (state=IDLE, grant=0, busy=0), timeout=1 for exactly one cycle, timeout_idx=owner. Normal release on that same cycle takes precedence: no timeout. When not defined: no counter, timeout and timeout_idx tied to 0, grant held indefinitely.

Test Plan:
- Reset mid-packet: owner 2 granted, 3 beats sent, reset=0 asynchronously -> grant=0, busy=0, beat_cnt=0 immediately; after release, req=4'b0100 -> grant=4'b0001? no: ptr=0 so req 2 granted, grant=4'b0100 one cycle later.
- Rotation: req=4'b1111 held, each owner sends 2 beats with last on 2nd -> grant sequence 0001,0010,0100,1000,0001, one idle cycle between each, beat_cnt=2 at each release.
- Skip idle requesters: ptr=1 after granting 0, req=4'b1001 -> grant 1000, then 0001.
- Abandon: owner 1 drops req after 1 beat -> release next edge, timeout=0, beat_cnt=1, next grant to next requester after one idle cycle.
- Saturation: CNT_W=4, 20 beats before last -> beat_cnt stops at 15.
- Watchdog (ARB_WATCHDOG_EN, MAX_HOLD=8): owner 3 never sends last -> release after 8 GRANT cycles, timeout=1 one cycle, timeout_idx=3; with last on cycle 8 -> no timeout.

Source files
------------

// File: rtl/rr_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_port_arbiter_if
// Handshake bundle between the per-port input queues (master side) and the
// round-robin output-port arbiter (slave side).
//
//   req          requester -> arb  NUM_REQ  level request, held until packet ends
//   beat_valid   requester -> arb  1        owner moved one beat this cycle
//   last         requester -> arb  1        qualifies beat_valid: final beat
//   grant        arb -> requester  NUM_REQ  one-hot grant, registered
//   grant_idx    arb -> requester  IDX_W    index of current owner (valid when busy)
//   busy         arb -> requester  1        grant currently held
//   beat_cnt     arb -> requester  CNT_W    beats accepted in current packet
//   timeout      arb -> requester  1        one-cycle pulse on forced release
//   timeout_idx  arb -> requester  IDX_W    owner at the forced release
// -----------------------------------------------------------------------------
interface rr_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0] req;
    logic               beat_valid;
    logic               last;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;
    logic [CNT_W-1:0]   beat_cnt;
    logic               timeout;
    logic [IDX_W-1:0]   timeout_idx;

    modport master (
        output req, beat_valid, last,
        input  grant, grant_idx, busy, beat_cnt, timeout, timeout_idx
    );

    modport slave (
        input  req, beat_valid, last,
        output grant, grant_idx, busy, beat_cnt, timeout, timeout_idx
    );
endinterface

// File: rtl/rr_port_arbiter.sv
// -----------------------------------------------------------------------------
// rr_port_arbiter
// Packet-granular round-robin arbiter for the single output port. A grant is
// taken in IDLE, held for a whole packet (until beat_valid & last, or until
// the owner drops its request), then the arbiter spends one cycle in IDLE
// before the next grant. The search for the next owner starts at the
// requester after the previous winner.
//
// Ports:
//   clk    input  system clock, rising edge
//   reset  input  asynchronous active-low reset
//   bus    slave modport of rr_port_arbiter_if (req/beat_valid/last in,
//          grant/grant_idx/busy/beat_cnt/timeout/timeout_idx out)
//
// Optional feature macro: ARB_WATCHDOG_EN
//   Defined   : a hold counter forces release after MAX_HOLD GRANT cycles,
//               pulsing timeout for one cycle and recording timeout_idx.
//   Undefined : no hold counter; timeout and timeout_idx are tied to 0.
// -----------------------------------------------------------------------------
module rr_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    rr_port_arbiter_if.slave    bus
);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || CNT_W < 1) begin : g_bad_params
        $error("rr_port_arbiter: unsupported parameter values");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic               busy_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    // Next owner search and derived values
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic [IDX_W-1:0]   pos_idx;
    int                 pos;
    logic [CNT_W-1:0]   beat_cnt_d;
    logic               owner_req;
    logic               normal_rel;

    // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        pos_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (!win_found && bus.req[pos_idx]) begin
                win_found = 1'b1;
                win_idx   = pos_idx;
            end
        end
    end

    assign win_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    // Saturating beat counter: sticks at all-ones instead of wrapping.
    assign beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign owner_req  = bus.req[grant_idx_q];
    // Packet end or abandonment by the owner; both release identically.
    assign normal_rel = (bus.beat_valid && bus.last) || !owner_req;

`ifdef ARB_WATCHDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;
    logic [IDX_W-1:0]  timeout_idx_q;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            busy_q        <= 1'b0;
            beat_cnt_q    <= '0;
`ifdef ARB_WATCHDOG_EN
            hold_q        <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // beat_valid/last are ignored here; only requests matter.
                    if (win_found) begin
                        state_q     <= GRANT;
                        grant_q     <= NUM_REQ'(1) << win_idx;
                        grant_idx_q <= win_idx;
                        busy_q      <= 1'b1;
                        beat_cnt_q  <= '0;
                        ptr_q       <= win_next;
`ifdef ARB_WATCHDOG_EN
                        hold_q      <= '0;
`endif
                    end
                end

                GRANT: begin
                    // Other requesters are not looked at until IDLE.
                    if (bus.beat_valid) begin
                        beat_cnt_q <= beat_cnt_d;
                    end
                    if (normal_rel) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
`ifdef ARB_WATCHDOG_EN
                    // A normal release on the final hold cycle wins over the
                    // watchdog, so no timeout is reported in that case.
                    else if (hold_q == HOLD_LAST) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        busy_q        <= 1'b0;
                        timeout_q     <= 1'b1;
                        timeout_idx_q <= grant_idx_q;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = busy_q;
    assign bus.beat_cnt  = beat_cnt_q;

`ifdef ARB_WATCHDOG_EN
    assign bus.timeout     = timeout_q;
    assign bus.timeout_idx = timeout_idx_q;
`else
    assign bus.timeout     = 1'b0;
    assign bus.timeout_idx = '0;
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_port_arbiter
// Self-checking bench for rr_port_arbiter (NUM_REQ=4, CNT_W=4, MAX_HOLD=8).
// A packet-level reference model tracks owner, rotation pointer, beat count
// and watchdog hold time; a compare process checks every DUT output against
// it on each falling edge. Directed scenarios add literal expectations, then
// a randomized phase exercises arbitrary request/beat patterns.
// Works with and without ARB_WATCHDOG_EN defined.
// -----------------------------------------------------------------------------
module tb_rr_port_arbiter;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int CW       = 4;
    localparam int MAX_HOLD = 8;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic clk;
    logic reset;

    rr_port_arbiter_if #(.NUM_REQ(N), .IDX_W(IW), .CNT_W(CW)) bus ();

    rr_port_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (IW),
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int busy;
        int owner;
        int ptr;
        int cnt;
        int hold;
        int to;
        int tidx;
    } model_t;

    localparam model_t M_RESET = '{busy: 0, owner: 0, ptr: 0, cnt: 0, hold: 0, to: 0, tidx: 0};

    model_t m;

    function automatic model_t model_step(model_t cur, logic [N-1:0] r, logic bv, logic ls);
        model_t nx;
        bit     rel;
        nx    = cur;
        nx.to = 0;
        if (cur.busy == 0) begin
            // First requester at or after ptr in circular order wins.
            for (int k = 0; k < N; k++) begin
                int i;
                i = (cur.ptr + k) % N;
                if (nx.busy == 0 && r[i]) begin
                    nx.busy  = 1;
                    nx.owner = i;
                    nx.cnt   = 0;
                    nx.hold  = 0;
                    nx.ptr   = (i + 1) % N;
                end
            end
        end else begin
            if (bv) nx.cnt = (cur.cnt + 1 > CNT_MAX) ? CNT_MAX : cur.cnt + 1;
            rel     = (bv && ls) || !r[cur.owner];
            nx.hold = cur.hold + 1;
            if (rel) begin
                nx.busy = 0;
            end
`ifdef ARB_WATCHDOG_EN
            else if (cur.hold + 1 >= MAX_HOLD) begin
                nx.busy = 0;
                nx.to   = 1;
                nx.tidx = cur.owner;
            end
`endif
        end
        return nx;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= M_RESET;
        else        m <= model_step(m, bus.req, bus.beat_valid, bus.last);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("grant", 32'(bus.grant), (m.busy != 0) ? (32'd1 << m.owner) : 32'd0);
            check("busy", 32'(bus.busy), 32'(m.busy));
            if (m.busy != 0) check("grant_idx", 32'(bus.grant_idx), 32'(m.owner));
            check("beat_cnt", 32'(bus.beat_cnt), 32'(m.cnt));
            check("timeout", 32'(bus.timeout), 32'(m.to));
            check("timeout_idx", 32'(bus.timeout_idx), 32'(m.tidx));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic bv, input logic ls);
        bus.req        = r;
        bus.beat_valid = bv;
        bus.last       = ls;
    endtask

    logic [N-1:0] rot_exp [5];

    initial begin
        rot_exp[0] = 4'b0001;
        rot_exp[1] = 4'b0010;
        rot_exp[2] = 4'b0100;
        rot_exp[3] = 4'b1000;
        rot_exp[4] = 4'b0001;

        reset = 1'b0;
        drive('0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", 32'(bus.beat_cnt), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Rotation with all four requesting, 2-beat packets.
        drive(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rot_grant", 32'(bus.grant), 32'(rot_exp[i]));
            drive(bus.req, 1'b1, 1'b0);
            step();
            drive(bus.req, 1'b1, 1'b1);
            step();
            check("rot_busy", 32'(bus.busy), 32'd0);
            check("rot_cnt", 32'(bus.beat_cnt), 32'd2);
            drive((i == 4) ? 4'b1001 : 4'b1111, 1'b0, 1'b0);
        end

        // Skip idle requesters: ptr=1, req=1001 -> 3 then 0.
        step();
        check("skip_grant3", 32'(bus.grant), 32'b1000);
        drive(4'b1001, 1'b1, 1'b1);
        step();
        drive(4'b1001, 1'b0, 1'b0);
        step();
        check("skip_grant0", 32'(bus.grant), 32'b0001);
        drive(4'b1001, 1'b1, 1'b1);
        step();
        check("skip_cnt", 32'(bus.beat_cnt), 32'd1);

        // Abandon: owner 1 drops after one beat.
        drive(4'b0110, 1'b0, 1'b0);
        step();
        check("ab_grant1", 32'(bus.grant), 32'b0010);
        drive(4'b0110, 1'b1, 1'b0);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        step();
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_timeout", 32'(bus.timeout), 32'd0);
        check("ab_cnt", 32'(bus.beat_cnt), 32'd1);
        step();
        check("ab_grant2", 32'(bus.grant), 32'b0100);
        drive(4'b0100, 1'b1, 1'b1);
        step();
        drive('0, 1'b0, 1'b0);

`ifndef ARB_WATCHDOG_EN
        // Saturation: 20 beats into a 4-bit counter.
        drive(4'b1000, 1'b0, 1'b0);
        step();
        check("sat_grant", 32'(bus.grant), 32'b1000);
        drive(4'b1000, 1'b1, 1'b0);
        repeat (20) step();
        check("sat_cnt", 32'(bus.beat_cnt), 32'd15);
        drive(4'b1000, 1'b1, 1'b1);
        step();
        check("sat_cnt_last", 32'(bus.beat_cnt), 32'd15);
        check("sat_busy", 32'(bus.busy), 32'd0);
        drive('0, 1'b0, 1'b0);
`endif

        // Reset in the middle of a packet owned by requester 2.
        drive(4'b0100, 1'b0, 1'b0);
        step();
        check("mr_grant", 32'(bus.grant), 32'b0100);
        drive(4'b0100, 1'b1, 1'b0);
        repeat (3) step();
        check("mr_cnt", 32'(bus.beat_cnt), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mr_grant_rst", 32'(bus.grant), 32'd0);
        check("mr_busy_rst", 32'(bus.busy), 32'd0);
        check("mr_cnt_rst", 32'(bus.beat_cnt), 32'd0);
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("mr_regrant", 32'(bus.grant), 32'b0100);
        drive(4'b0100, 1'b1, 1'b1);
        step();
        drive('0, 1'b0, 1'b0);

`ifdef ARB_WATCHDOG_EN
        // Watchdog: owner 3 never ends its packet.
        drive(4'b1000, 1'b0, 1'b0);
        step();
        check("wd_grant", 32'(bus.grant), 32'b1000);
        repeat (7) step();
        check("wd_busy7", 32'(bus.busy), 32'd1);
        check("wd_to7", 32'(bus.timeout), 32'd0);
        step();
        check("wd_busy8", 32'(bus.busy), 32'd0);
        check("wd_to8", 32'(bus.timeout), 32'd1);
        check("wd_tidx", 32'(bus.timeout_idx), 32'd3);
        step();
        check("wd_to_pulse", 32'(bus.timeout), 32'd0);
        check("wd_regrant", 32'(bus.grant), 32'b1000);
        repeat (7) step();
        drive(4'b1000, 1'b1, 1'b1);
        step();
        check("wd_last_busy", 32'(bus.busy), 32'd0);
        check("wd_last_to", 32'(bus.timeout), 32'd0);
        drive('0, 1'b0, 1'b0);
`endif

        // Randomized phase: slowly toggling requests, random beats.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            logic         bv;
            r = bus.req;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            bv = ($urandom_range(0, 2) != 0);
            drive(r, bv, bv && ($urandom_range(0, 3) == 0));
            step();
        end

        drive('0, 1'b0, 1'b0);
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
